bridge_ram2bus_rw: RTL and testbench
====================================

# bridge_ram2bus_rw

Parametrised read/write bridge from the RAM-style port (en/we/addr/be/data, delay stall) to the OCP-style bus master port. It is the general successor of the read-only bridge, adding writes (posted or acknowledged), a read-data capture register so responses are never lost when the next command stalls, error/timeout detection, and error bookkeeping. It sits between a core's instruction/data RAM port and the system bus.

## Interface
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width, a multiple of 8; BE_WIDTH = DATA_WIDTH/8.
- WRITE_POSTED, 1: 1 means a write completes on SCmdAccept; 0 means a write waits for a response like a read.
- TIMEOUT, 0: wait cycles before aborting a pending response; 0 disables the timeout.
- ERR_COUNT_WIDTH, 8, width of the saturating error counter.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ram_en, ram_we  in  1  RAM request and write select.
- ram_addr  in  ADDR_WIDTH  request address.
- ram_be  in  BE_WIDTH  byte enables.
- ram_data_w  in  DATA_WIDTH  write data.
- ram_data_r  out  DATA_WIDTH  read data.
- ram_delay  out  1  stall to the RAM master.
- MReset_n  out  1  equals ~reset.
- MCmd  out  3  command: IDLE=0, WR=1, RD=2.
- MAddr, MData, MByteEn  out  ADDR_WIDTH/DATA_WIDTH/BE_WIDTH  equal ram_addr, ram_data_w, ram_be.
- MRespAccept  out  1  constant 1.
- SCmdAccept  in  1  slave accepts the command.
- SResp  in  2  response: NULL=0, DVA=1, FAIL=2, ERR=3.
- SData  in  DATA_WIDTH  response data.
- err_clear  in  1  clears err_sticky and err_count.
- err_sticky  out  1  set on any error or timeout.
- err_count  out  ERR_COUNT_WIDTH  saturating error count.
- err_addr  out  ADDR_WIDTH  address of the most recent failed transaction.

## Operation
- State: `waiting` (response pending), `pend_addr`, `cap_data`, timeout counter (clog2(TIMEOUT+1) bits), and the error registers.
- resp_done = waiting && (SResp != NULL || timeout_hit).
- Commands may issue only when the bridge is free: `issue = ram_en && !reset && (!waiting || resp_done)`. MCmd = ram_we ? WR : RD when `issue`; otherwise IDLE.
- `accepted = issue && SCmdAccept`.
- ram_delay = reset || (waiting && !resp_done) || (ram_en && !accepted).
- Next `waiting`:
  - Set when `accepted` and the command is a read, or a write with WRITE_POSTED=0. `pend_addr` captures ram_addr.
  - Cleared when resp_done and there is no new waiting acceptance.
- Response DVA on a read: `cap_data` <= SData. FAIL, ERR, or a timeout: `cap_data` <= 0 and the error is recorded. Write responses never update `cap_data`.
- ram_data_r = SData in a cycle with a read DVA resp_done; otherwise `cap_data`. Read data is therefore held if the next command stalls, and is valid in the first cycle after the read where ram_delay=0.
- Errors (FAIL/ERR/timeout):
  - err_sticky <= 1.
  - err_count increments, saturating at all-ones.
  - err_addr <= pend_addr.
  - err_clear in the same cycle as an error: the error wins (sticky=1, count=1).
- SResp != NULL while not waiting is ignored. Responses after a timeout abort are unsupported; the slave must not send them.
- Reset values: waiting=0, cap_data=0, timeout counter=0, err_sticky=0, err_count=0, err_addr=0. During reset: MCmd=IDLE, ram_delay=1, MReset_n=0.
- Reset mid-transaction drops the pending transaction and records no error.

## Timing
- Zero-wait slave (SCmdAccept=1, DVA one cycle later):
  - Read in cycle n with ram_delay=0; ram_data_r valid in n+1.
  - Back-to-back reads run one per cycle; the next command issues in the same cycle the previous DVA arrives.
- Posted write: single cycle when SCmdAccept=1, with no wait state.
- Timeout: the wait-cycle count starts at 1 in the cycle after acceptance. If SResp is still NULL in wait cycle TIMEOUT, timeout_hit is asserted in that cycle and resp_done occurs there.
- All error registers update on the clock edge following the failing resp_done.

## Test plan
- Zero-wait slave, reads to 0x10, 0x14, 0x18 returning 0xA, 0xB, 0xC → MCmd=RD three consecutive cycles, ram_delay always 0, ram_data_r = 0xA, 0xB, 0xC on cycles n+1..n+3.
- DVA with 0x55 arrives while the next read sees SCmdAccept=0 for 2 cycles → ram_delay high for 2 cycles, then ram_data_r=0x55 in the first cycle delay drops.
- WRITE_POSTED=1 write then read → write takes one cycle with no wait; read waits for DVA. WRITE_POSTED=0 → write stalls until DVA.
- Read to 0x40 answered with ERR → ram_data_r=0, err_sticky=1, err_count=1, err_addr=0x40. err_clear asserted together with a second error → count=1.
- TIMEOUT=4, slave never responds → ram_delay high for wait cycles 1..3, released in wait cycle 4, ram_data_r=0, err_count increments. 256 errors with width 8 → err_count saturates at 255.
- Reset asserted while waiting → MCmd=IDLE, ram_delay=1, MReset_n=0; after release no error recorded, waiting=0.

Source files
------------

// File: rtl/bridge_ram2bus_rw_if.sv
// rtl/bridge_ram2bus_rw_if.sv - OCP-style bus master/slave signal bundle
interface bridge_ram2bus_rw_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  MReset_n;
  logic [2:0]            MCmd;
  logic [ADDR_WIDTH-1:0] MAddr;
  logic [DATA_WIDTH-1:0] MData;
  logic [BE_WIDTH-1:0]   MByteEn;
  logic                  MRespAccept;
  logic                  SCmdAccept;
  logic [1:0]            SResp;
  logic [DATA_WIDTH-1:0] SData;

  modport master (
    output MReset_n, MCmd, MAddr, MData, MByteEn, MRespAccept,
    input  SCmdAccept, SResp, SData
  );

  modport slave (
    input  MReset_n, MCmd, MAddr, MData, MByteEn, MRespAccept,
    output SCmdAccept, SResp, SData
  );
endinterface

// File: rtl/bridge_ram2bus_rw.sv
// rtl/bridge_ram2bus_rw.sv - RAM-port to OCP-bus read/write bridge with error tracking
module bridge_ram2bus_rw #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WRITE_POSTED    = 1,
  parameter int TIMEOUT         = 0,
  parameter int ERR_COUNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ram_en,
  input  logic                       ram_we,
  input  logic [ADDR_WIDTH-1:0]      ram_addr,
  input  logic [DATA_WIDTH/8-1:0]    ram_be,
  input  logic [DATA_WIDTH-1:0]      ram_data_w,
  output logic [DATA_WIDTH-1:0]      ram_data_r,
  output logic                       ram_delay,
  bridge_ram2bus_rw_if.master        bus,
  input  logic                       err_clear,
  output logic                       err_sticky,
  output logic [ERR_COUNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]      err_addr
);

  // Counter width must be at least one bit even when the timeout is disabled.
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;

  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_FAIL = 2'd2;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic                  waiting;
  logic                  timeout_hit;
  logic                  resp_done;
  logic                  resp_err;
  logic                  issue;
  logic                  accepted;
  logic                  wait_new;

  logic                  pend_we_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic [DATA_WIDTH-1:0] cap_data_q;
  logic [TMO_W-1:0]      tmo_cnt_q;

  logic                       err_sticky_q;
  logic [ERR_COUNT_WIDTH-1:0] err_count_q;
  logic [ADDR_WIDTH-1:0]      err_addr_q;

  assign waiting = (state_q == S_WAIT);

  // The counter reads TIMEOUT in the last wait cycle; a late NULL there aborts.
  assign timeout_hit = (TIMEOUT != 0) && waiting && (bus.SResp == RESP_NULL) &&
                       (tmo_cnt_q == TMO_W'(TIMEOUT));

  assign resp_done = waiting && ((bus.SResp != RESP_NULL) || timeout_hit);
  assign resp_err  = resp_done && (timeout_hit || (bus.SResp == RESP_FAIL) ||
                                   (bus.SResp == RESP_ERR));

  // A new command may overlap the cycle in which the previous response lands.
  assign issue    = ram_en && !reset && (!waiting || resp_done);
  assign accepted = issue && bus.SCmdAccept;

  // Reads always wait for data; writes wait only in acknowledged mode.
  assign wait_new = accepted && (!ram_we || (WRITE_POSTED == 0));

  assign bus.MReset_n    = ~reset;
  assign bus.MCmd        = issue ? (ram_we ? CMD_WR : CMD_RD) : CMD_IDLE;
  assign bus.MAddr       = ram_addr;
  assign bus.MData       = ram_data_w;
  assign bus.MByteEn     = ram_be;
  assign bus.MRespAccept = 1'b1;

  assign ram_delay = reset || (waiting && !resp_done) || (ram_en && !accepted);

  // Bypass fresh read data so back-to-back reads need no extra cycle.
  assign ram_data_r = (resp_done && !pend_we_q && (bus.SResp == RESP_DVA)) ?
                      bus.SData : cap_data_q;

  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign err_addr   = err_addr_q;

  // Transaction state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter WAIT on a waiting acceptance, leave when the response completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (wait_new) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resp_done && !wait_new) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending-transaction bookkeeping, timeout counter and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_we_q   <= 1'b0;
      pend_addr_q <= '0;
      cap_data_q  <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      if (wait_new) begin
        pend_we_q   <= ram_we;
        pend_addr_q <= ram_addr;
      end

      if (wait_new) begin
        tmo_cnt_q <= TMO_W'(1);
      end else if (waiting && !resp_done) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else if (resp_done) begin
        tmo_cnt_q <= '0;
      end

      if (resp_done && !pend_we_q) begin
        if (bus.SResp == RESP_DVA) begin
          cap_data_q <= bus.SData;
        end else begin
          cap_data_q <= '0;
        end
      end
    end
  end

  // Error bookkeeping; a simultaneous error overrides err_clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      err_addr_q   <= '0;
    end else if (resp_err) begin
      err_sticky_q <= 1'b1;
      err_addr_q   <= pend_addr_q;
      if (err_clear) begin
        err_count_q <= ERR_COUNT_WIDTH'(1);
      end else if (err_count_q != {ERR_COUNT_WIDTH{1'b1}}) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end else if (err_clear) begin
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end
  end

endmodule

// File: tb/tb_bridge_ram2bus_rw.sv
// tb/tb_bridge_ram2bus_rw.sv - directed scoreboard bench for bridge_ram2bus_rw
module tb_bridge_ram2bus_rw;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = 8;

  localparam logic [1:0] R_NULL = 2'd0;
  localparam logic [1:0] R_DVA  = 2'd1;
  localparam logic [1:0] R_FAIL = 2'd2;
  localparam logic [1:0] R_ERR  = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          ram_en = 1'b0;
  logic          ram_we = 1'b0;
  logic [AW-1:0] ram_addr = '0;
  logic [BW-1:0] ram_be = '1;
  logic [DW-1:0] ram_data_w = '0;
  logic          err_clear = 1'b0;
  logic          s_cmd_accept = 1'b0;
  logic [1:0]    s_resp = 2'd0;
  logic [DW-1:0] s_data = '0;

  logic rst_v = 1'b1;
  logic clr_v = 1'b0;

  logic [DW-1:0] a_data_r, b_data_r;
  logic          a_delay, b_delay;
  logic          a_sticky, b_sticky;
  logic [CW-1:0] a_count, b_count;
  logic [AW-1:0] a_eaddr, b_eaddr;

  bridge_ram2bus_rw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  bridge_ram2bus_rw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  assign bus_a.SCmdAccept = s_cmd_accept;
  assign bus_a.SResp      = s_resp;
  assign bus_a.SData      = s_data;
  assign bus_b.SCmdAccept = s_cmd_accept;
  assign bus_b.SResp      = s_resp;
  assign bus_b.SData      = s_data;

  bridge_ram2bus_rw #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRITE_POSTED(1), .TIMEOUT(4), .ERR_COUNT_WIDTH(CW)
  ) dut_a (
    .clk(clk), .reset(reset), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_be(ram_be), .ram_data_w(ram_data_w), .ram_data_r(a_data_r), .ram_delay(a_delay),
    .bus(bus_a.master), .err_clear(err_clear), .err_sticky(a_sticky), .err_count(a_count),
    .err_addr(a_eaddr)
  );

  bridge_ram2bus_rw #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRITE_POSTED(0), .TIMEOUT(0), .ERR_COUNT_WIDTH(CW)
  ) dut_b (
    .clk(clk), .reset(reset), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_be(ram_be), .ram_data_w(ram_data_w), .ram_data_r(b_data_r), .ram_delay(b_delay),
    .bus(bus_b.master), .err_clear(err_clear), .err_sticky(b_sticky), .err_count(b_count),
    .err_addr(b_eaddr)
  );

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the next expected read word and compares it against both bridges.
  task automatic chk_rd(input string tag);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_a"}, 64'(a_data_r), 64'(e));
      chk({tag, "_b"}, 64'(b_data_r), 64'(e));
    end
  endtask

  // One clock cycle: drive inputs just after the edge, return at the falling edge.
  task automatic cyc(input logic en, input logic we, input logic [AW-1:0] addr,
                     input logic acc, input logic [1:0] resp, input logic [DW-1:0] sd);
    @(posedge clk);
    #1;
    reset        = rst_v;
    err_clear    = clr_v;
    ram_en       = en;
    ram_we       = we;
    ram_addr     = addr;
    ram_data_w   = 32'h1234_0000 | addr;
    s_cmd_accept = acc;
    s_resp       = resp;
    s_data       = sd;
    @(negedge clk);
  endtask

  initial begin
    // Reset with a request pending at the RAM port.
    rst_v = 1'b1;
    cyc(1, 0, 32'h10, 1, R_NULL, 0);
    chk("rst_mcmd", 64'(bus_a.MCmd), 64'd0);
    chk("rst_delay", 64'(a_delay), 64'd1);
    chk("rst_mreset_n", 64'(bus_a.MReset_n), 64'd0);
    cyc(1, 0, 32'h10, 1, R_NULL, 0);
    chk("rst_data", 64'(a_data_r), 64'd0);
    chk("rst_count", 64'(a_count), 64'd0);
    chk("rst_sticky", 64'(a_sticky), 64'd0);
    chk("rst_eaddr", 64'(a_eaddr), 64'd0);

    // Back-to-back reads against a zero-wait slave.
    rst_v = 1'b0;
    cyc(1, 0, 32'h10, 1, R_NULL, 0);
    chk("b2b_cmd0", 64'(bus_a.MCmd), 64'd2);
    chk("b2b_dly0", 64'(a_delay), 64'd0);
    chk("b2b_addr0", 64'(bus_a.MAddr), 64'h10);
    chk("mreset_n_run", 64'(bus_a.MReset_n), 64'd1);
    exp_q.push_back(32'hA);
    cyc(1, 0, 32'h14, 1, R_DVA, 32'hA);
    chk("b2b_cmd1", 64'(bus_a.MCmd), 64'd2);
    chk("b2b_dly1", 64'(a_delay), 64'd0);
    chk_rd("b2b_d1");
    exp_q.push_back(32'hB);
    cyc(1, 0, 32'h18, 1, R_DVA, 32'hB);
    chk("b2b_cmd2", 64'(bus_a.MCmd), 64'd2);
    chk("b2b_dly2", 64'(a_delay), 64'd0);
    chk_rd("b2b_d2");
    exp_q.push_back(32'hC);
    cyc(0, 0, 32'h0, 1, R_DVA, 32'hC);
    chk("b2b_cmd3", 64'(bus_a.MCmd), 64'd0);
    chk("b2b_dly3", 64'(a_delay), 64'd0);
    chk_rd("b2b_d3");
    cyc(0, 0, 32'h0, 1, R_NULL, 0);
    chk("b2b_hold", 64'(a_data_r), 64'hC);

    // Response arrives while the next read is refused for two cycles.
    cyc(1, 0, 32'h20, 1, R_NULL, 0);
    chk("stall_dly0", 64'(a_delay), 64'd0);
    exp_q.push_back(32'h55);
    cyc(1, 0, 32'h24, 0, R_DVA, 32'h55);
    chk("stall_dly1", 64'(a_delay), 64'd1);
    cyc(1, 0, 32'h24, 0, R_NULL, 0);
    chk("stall_dly2", 64'(a_delay), 64'd1);
    cyc(1, 0, 32'h24, 1, R_NULL, 0);
    chk("stall_dly3", 64'(a_delay), 64'd0);
    chk_rd("stall_held");
    exp_q.push_back(32'h66);
    cyc(0, 0, 32'h0, 1, R_DVA, 32'h66);
    chk_rd("stall_next");
    cyc(0, 0, 32'h0, 1, R_NULL, 0);

    // Write: posted in A, acknowledged in B.
    cyc(1, 1, 32'h30, 1, R_NULL, 0);
    chk("wr_cmd", 64'(bus_a.MCmd), 64'd1);
    chk("wr_mdata", 64'(bus_a.MData), 64'h1234_0030);
    chk("wr_dly_a", 64'(a_delay), 64'd0);
    chk("wr_dly_b", 64'(b_delay), 64'd0);
    cyc(0, 0, 32'h0, 1, R_NULL, 0);
    chk("wr_wait_a", 64'(a_delay), 64'd0);
    chk("wr_wait_b", 64'(b_delay), 64'd1);
    cyc(0, 0, 32'h0, 1, R_DVA, 32'hEE);
    chk("wr_ack_b", 64'(b_delay), 64'd0);
    chk("wr_nodata_a", 64'(a_data_r), 64'h66);
    chk("wr_nodata_b", 64'(b_data_r), 64'h66);
    cyc(0, 0, 32'h0, 1, R_NULL, 0);
    chk("wr_idle_b", 64'(b_delay), 64'd0);
    cyc(1, 0, 32'h34, 1, R_NULL, 0);
    chk("rd_after_wr_dly0", 64'(a_delay), 64'd0);
    cyc(0, 0, 32'h0, 1, R_NULL, 0);
    chk("rd_after_wr_wait", 64'(a_delay), 64'd1);
    exp_q.push_back(32'h88);
    cyc(0, 0, 32'h0, 1, R_DVA, 32'h88);
    chk("rd_after_wr_dly2", 64'(a_delay), 64'd0);
    chk_rd("rd_after_wr");
    cyc(0, 0, 32'h0, 1, R_NULL, 0);

    // Timeout in A (TIMEOUT=4); B has none and keeps waiting.
    cyc(1, 0, 32'h50, 1, R_NULL, 0);
    chk("tmo_dly0", 64'(a_delay), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 32'h0, 1, R_NULL, 0);
      chk($sformatf("tmo_wait%0d", i), 64'(a_delay), 64'd1);
    end
    cyc(0, 0, 32'h0, 1, R_NULL, 0);
    chk("tmo_release", 64'(a_delay), 64'd0);
    chk("tmo_b_wait", 64'(b_delay), 64'd1);
    cyc(1, 0, 32'h60, 1, R_NULL, 0);
    chk("tmo_data", 64'(a_data_r), 64'd0);
    chk("tmo_count", 64'(a_count), 64'd1);
    chk("tmo_sticky", 64'(a_sticky), 64'd1);
    chk("tmo_eaddr", 64'(a_eaddr), 64'h50);
    chk("tmo_b_nocount", 64'(b_count), 64'd0);
    chk("tmo_b_cmd", 64'(bus_b.MCmd), 64'd0);

    // Reset while both bridges wait.
    rst_v = 1'b1;
    cyc(1, 0, 32'h64, 1, R_NULL, 0);
    chk("rstw_cmd_a", 64'(bus_a.MCmd), 64'd0);
    chk("rstw_cmd_b", 64'(bus_b.MCmd), 64'd0);
    chk("rstw_dly", 64'(a_delay), 64'd1);
    chk("rstw_mreset_n", 64'(bus_b.MReset_n), 64'd0);
    rst_v = 1'b0;
    cyc(0, 0, 32'h0, 1, R_NULL, 0);
    chk("rstw_dly_a", 64'(a_delay), 64'd0);
    chk("rstw_dly_b", 64'(b_delay), 64'd0);
    chk("rstw_count", 64'(a_count), 64'd0);
    cyc(0, 0, 32'h0, 1, R_NULL, 0);
    chk("rstw_idle_b", 64'(b_delay), 64'd0);
    chk("rstw_sticky_b", 64'(b_sticky), 64'd0);

    // ERR on a read, then err_clear colliding with a FAIL.
    cyc(1, 0, 32'h3C, 1, R_NULL, 0);
    exp_q.push_back(32'h99);
    cyc(0, 0, 32'h0, 1, R_DVA, 32'h99);
    chk_rd("pre_err");
    cyc(1, 0, 32'h40, 1, R_NULL, 0);
    cyc(0, 0, 32'h0, 1, R_ERR, 32'hDEAD);
    chk("err_notyet", 64'(a_count), 64'd0);
    cyc(0, 0, 32'h0, 1, R_NULL, 0);
    chk("err_data_a", 64'(a_data_r), 64'd0);
    chk("err_data_b", 64'(b_data_r), 64'd0);
    chk("err_sticky", 64'(a_sticky), 64'd1);
    chk("err_count_b", 64'(b_count), 64'd1);
    chk("err_eaddr", 64'(a_eaddr), 64'h40);
    cyc(1, 0, 32'h44, 1, R_NULL, 0);
    clr_v = 1'b1;
    cyc(0, 0, 32'h0, 1, R_FAIL, 0);
    clr_v = 1'b0;
    cyc(0, 0, 32'h0, 1, R_NULL, 0);
    chk("clr_vs_err_count", 64'(a_count), 64'd1);
    chk("clr_vs_err_sticky", 64'(b_sticky), 64'd1);
    chk("clr_vs_err_eaddr", 64'(a_eaddr), 64'h44);
    clr_v = 1'b1;
    cyc(0, 0, 32'h0, 1, R_NULL, 0);
    clr_v = 1'b0;
    cyc(0, 0, 32'h0, 1, R_NULL, 0);
    chk("clr_count", 64'(a_count), 64'd0);
    chk("clr_sticky", 64'(a_sticky), 64'd0);
    chk("clr_keeps_eaddr", 64'(a_eaddr), 64'h44);

    // Continuous ERR responses: one error per cycle until the counter saturates.
    for (int i = 0; i < 300; i++) begin
      cyc(1, 0, 32'h100 + 32'(i * 4), 1, R_ERR, 0);
      if (i == 1) chk("sat_ignore_idle_resp", 64'(a_count), 64'd0);
      if (i == 101) begin
        chk("sat_mid_a", 64'(a_count), 64'd100);
        chk("sat_mid_b", 64'(b_count), 64'd100);
      end
    end
    cyc(0, 0, 32'h0, 1, R_NULL, 0);
    chk("sat_a", 64'(a_count), 64'd255);
    chk("sat_b", 64'(b_count), 64'd255);
    chk("sat_eaddr", 64'(a_eaddr), 64'h100 + 64'(298 * 4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
